leb128_fetch: RTL and testbench

- Immediate-operand fetch stage sitting between the genrom instruction memory and the cpu decode logic.
- On request, reads a window of bytes at a given PC through the same addr/extra/data/error memory port the cpu uses.
- Decodes one LEB128 immediate, signed or unsigned, 32- or 64-bit, and returns the value, its byte length and any error.
- The cpu uses the returned length to advance its PC past the immediate.

---
 rtl/leb128_fetch.sv | 187 ++++++++++++++++++
 tb/tb_leb128_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_fetch.sv
// rtl/leb128_fetch.sv - LEB128 immediate fetch/decode stage between instruction memory and decode.
// Optional final-byte range checking is enabled by defining LEB128_STRICT_EN.
module leb128_fetch #(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MEM_DEPTH:0]            addr,
  input  logic                          is_signed,
  input  logic                          is_64,
  output logic                          busy,
  output logic                          done,
  output logic [63:0]                   value,
  output logic [3:0]                    length,
  output logic [1:0]                    error,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error
);

  localparam int WB = (2**MEM_EXTRA) * 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DECODE, S_DONE} state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MEM      = 2'd1;
  localparam logic [1:0] ERR_TOO_LONG = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [63:0]          value_q, value_d;
  logic [3:0]           length_q, length_d;
  logic [1:0]           error_q, error_d;
  logic [MEM_DEPTH:0]   mem_addr_q, mem_addr_d;
  logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
  logic                 signed_q, signed_d;
  logic                 is64_q, is64_d;
  logic [WB-1:0]        win_q, win_d;
  logic [63:0]          acc_q, acc_d;
  logic [3:0]           cnt_q, cnt_d;

  logic [7:0]  cur_byte;
  logic [6:0]  shamt, end_sh;
  logic [63:0] acc_new, fill, sext_val, fin_val;
  logic [3:0]  cnt_inc, max_bytes;
  logic        range_bad;

  always_comb begin
    cur_byte  = win_q[WB-1 -: 8];
    shamt     = 7'(cnt_q) * 7'd7;
    end_sh    = shamt + 7'd7;
    // The 10th byte lands at bit 63, so anything past bit 63 simply falls off.
    acc_new   = acc_q | ({57'd0, cur_byte[6:0]} << shamt);
    fill      = (end_sh < 7'd64) ? (~64'd0 << end_sh) : 64'd0;
    sext_val  = (signed_q && cur_byte[6]) ? (acc_new | fill) : acc_new;
    if (is64_q)
      fin_val = sext_val;
    else if (signed_q)
      fin_val = {{32{sext_val[31]}}, sext_val[31:0]};
    else
      fin_val = {32'd0, sext_val[31:0]};
    cnt_inc   = cnt_q + 4'd1;
    max_bytes = is64_q ? 4'd10 : 4'd5;
    range_bad = 1'b0;
`ifdef LEB128_STRICT_EN
    if (cnt_inc == max_bytes) begin
      if (is64_q)
        range_bad = signed_q ? (cur_byte[6:1] != {6{cur_byte[0]}}) : (cur_byte[6:1] != 6'd0);
      else
        range_bad = signed_q ? (cur_byte[6:4] != {3{cur_byte[3]}}) : (cur_byte[6:4] != 3'd0);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    value_d     = value_q;
    length_d    = length_q;
    error_d     = error_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;
    signed_d    = signed_q;
    is64_d      = is64_q;
    win_d       = win_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d  = addr;
          mem_extra_d = is_64 ? MEM_EXTRA'(9) : MEM_EXTRA'(4);
          signed_d    = is_signed;
          is64_d      = is_64;
          busy_d      = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_error) begin
          value_d  = 64'd0;
          length_d = 4'd0;
          error_d  = ERR_MEM;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          win_d   = mem_data;
          acc_d   = 64'd0;
          cnt_d   = 4'd0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        acc_d = acc_new;
        cnt_d = cnt_inc;
        win_d = win_q << 8;
        if (!cur_byte[7]) begin
          length_d = cnt_inc;
          value_d  = range_bad ? 64'd0 : fin_val;
          error_d  = range_bad ? ERR_RANGE : ERR_NONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_inc == max_bytes) begin
          length_d = max_bytes;
          value_d  = 64'd0;
          error_d  = ERR_TOO_LONG;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= 64'd0;
      length_q    <= 4'd0;
      error_q     <= ERR_NONE;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      signed_q    <= 1'b0;
      is64_q      <= 1'b0;
      win_q       <= '0;
      acc_q       <= 64'd0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      value_q     <= value_d;
      length_q    <= length_d;
      error_q     <= error_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
      signed_q    <= signed_d;
      is64_q      <= is64_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign length    = length_q;
  assign error     = error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_extra = mem_extra_q;

endmodule

// File: tb/tb_leb128_fetch.sv
// tb/tb_leb128_fetch.sv - self-checking bench for leb128_fetch (vector table, corner sequences, random vs model).
module tb_leb128_fetch;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [6:0]   addr = '0;
  logic         is_signed = 1'b0;
  logic         is_64 = 1'b0;
  logic         busy, done;
  logic [63:0]  value;
  logic [3:0]   length;
  logic [1:0]   error;
  logic [6:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error = 1'b0;

  logic [7:0] mem [128];
  int nvec = 0;
  int nmis = 0;

  leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .is_signed(is_signed), .is_64(is_64),
    .busy(busy), .done(done), .value(value), .length(length), .error(error),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_data = '0;
    for (int k = 0; k < 16; k++)
      mem_data[(15-k)*8 +: 8] = mem[(int'(mem_addr) + k) % 128];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: weighted sum of 7-bit groups, two's-complement offset for negatives, then range/truncate.
  function automatic void ref_decode(input logic [6:0] a, input logic sgn, input logic w64, input logic merr,
                                     output logic [63:0] v, output logic [3:0] l, output logic [1:0] e);
    int maxb = w64 ? 10 : 5;
    int n = 0;
    int nbits = w64 ? 64 : 32;
    logic [7:0] b = 8'd0;
    logic [127:0] u = '0;
    logic signed [127:0] s, lim;
    if (merr) begin
      v = 0; l = 0; e = 1;
      return;
    end
    for (int i = 0; i < maxb; i++) begin
      b = mem[(int'(a) + i) % 128];
      u = u + ({121'd0, b[6:0]} << (7*i));
      if (!b[7]) begin n = i + 1; break; end
    end
    if (n == 0) begin
      v = 0; l = 4'(maxb); e = 2;
      return;
    end
    s = $signed(u);
    if (sgn && b[6]) s = s - (128'sd1 <<< (7*n));
    lim = 128'sd1 <<< (nbits - (sgn ? 1 : 0));
    l = 4'(n);
    e = 0;
    if (w64) v = s[63:0];
    else if (sgn) v = {{32{s[31]}}, s[31:0]};
    else v = {32'd0, s[31:0]};
`ifdef LEB128_STRICT_EN
    if (sgn ? !(s >= -lim && s < lim) : !(s < lim)) begin
      v = 0; e = 3;
    end
`else
    if (lim == 0) v = v;
`endif
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the done cycle plus one probe cycle.
  task automatic do_op(input logic [6:0] a, input logic sgn, input logic w64, input int poke_at,
                       output int lat, output logic [63:0] v, output logic [3:0] l, output logic [1:0] e,
                       output logic busy_ok, output logic [6:0] cap_addr, output logic [3:0] cap_extra,
                       output logic probe_ok);
    addr = a; is_signed = sgn; is_64 = w64; start = 1'b1;
    lat = -1; busy_ok = 1'b1; v = '0; l = '0; e = '0; cap_addr = '0; cap_extra = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0; addr = 7'($urandom); is_signed = 1'($urandom); is_64 = 1'($urandom);
      if (c == 1) begin cap_addr = mem_addr; cap_extra = mem_extra; end
      if (done) begin
        if (busy) busy_ok = 1'b0;
        lat = c; v = value; l = length; e = error;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (c == poke_at) start = 1'b1;
    end
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    probe_ok = !busy && !done && value === v && length === l && error === e;
  endtask

  typedef struct {
    logic [6:0]  a;
    logic        sgn;
    logic        w64;
    logic [79:0] bytes;
    int          poke;
    logic [63:0] ev;
    logic [3:0]  el;
    logic [1:0]  ee;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic run_vec(input vec_t t, input string tag);
    int lat;
    logic [63:0] v;
    logic [3:0] l, cx;
    logic [1:0] e;
    logic bok, pok;
    logic [6:0] ca;
    for (int i = 0; i < 10; i++) mem[(int'(t.a) + i) % 128] = t.bytes[79 - 8*i -: 8];
    mem_error = 1'b0;
    do_op(t.a, t.sgn, t.w64, t.poke, lat, v, l, e, bok, ca, cx, pok);
    chk({tag, " value"}, v, t.ev);
    chk({tag, " length"}, 64'(l), 64'(t.el));
    chk({tag, " error"}, 64'(e), 64'(t.ee));
    chk({tag, " latency"}, 64'(lat), 64'(t.lat));
    chk({tag, " busy"}, 64'(bok), 64'd1);
    chk({tag, " mem_addr"}, 64'(ca), 64'(t.a));
    chk({tag, " mem_extra"}, 64'(cx), t.w64 ? 64'd9 : 64'd4);
    chk({tag, " start_in_done"}, 64'(pok), 64'd1);
  endtask

  initial begin
    int lat, ndone;
    logic [63:0] v, ev;
    logic [3:0] l, el, cx;
    logic [1:0] e, ee;
    logic bok, pok;
    logic [6:0] ca;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    tbl[0] = '{7'd33,  1'b0, 1'b0, {8'h2A, 72'h0},                       -1, 64'd42,                  4'd1,  2'd0, 3};
    tbl[1] = '{7'd5,   1'b0, 1'b1, {24'hE58E26, 56'h0},                  3,  64'd624485,              4'd3,  2'd0, 5};
    tbl[2] = '{7'd90,  1'b1, 1'b1, {8'h7F, 72'h0},                       -1, 64'hFFFFFFFFFFFFFFFF,    4'd1,  2'd0, 3};
    tbl[3] = '{7'd17,  1'b1, 1'b0, {24'hC0BB78, 56'h0},                  -1, 64'hFFFFFFFFFFFE1DC0,    4'd3,  2'd0, 5};
    tbl[4] = '{7'd60,  1'b0, 1'b0, {40'h8080808080, 40'h0},              2,  64'd0,                   4'd5,  2'd2, 7};
`ifdef LEB128_STRICT_EN
    tbl[5] = '{7'd40,  1'b0, 1'b0, {40'hFFFFFFFF7F, 40'h0},              -1, 64'd0,                   4'd5,  2'd3, 7};
`else
    tbl[5] = '{7'd40,  1'b0, 1'b0, {40'hFFFFFFFF7F, 40'h0},              -1, 64'h00000000FFFFFFFF,    4'd5,  2'd0, 7};
`endif
    tbl[6] = '{7'd100, 1'b0, 1'b1, 80'h80808080808080808001,             5,  64'h8000000000000000,    4'd10, 2'd0, 12};
    tbl[7] = '{7'd0,   1'b0, 1'b1, 80'h80808080808080808080,             -1, 64'd0,                   4'd10, 2'd2, 12};
    tbl[8] = '{7'd126, 1'b0, 1'b0, {24'h818101, 56'h0},                  -1, 64'd16513,               4'd3,  2'd0, 5};
    tbl[9] = '{7'd70,  1'b1, 1'b1, 80'hFFFFFFFFFFFFFFFFFF7F,             -1, 64'hFFFFFFFFFFFFFFFF,    4'd10, 2'd0, 12};

    @(negedge clk); @(negedge clk);
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("reset value", value, 64'd0);
    chk("reset len/err", {58'd0, length, error}, 64'd0);
    chk("reset mem port", {53'd0, mem_addr, mem_extra}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Memory error, with a stray start during WAIT.
    mem_error = 1'b1;
    do_op(7'd12, 1'b0, 1'b1, 1, lat, v, l, e, bok, ca, cx, pok);
    mem_error = 1'b0;
    chk("memerr value", v, 64'd0);
    chk("memerr length", 64'(l), 64'd0);
    chk("memerr error", 64'(e), 64'd1);
    chk("memerr latency", 64'(lat), 64'd2);
    chk("memerr start_ignored", 64'(pok), 64'd1);

    // Asynchronous reset in the middle of a 10-byte decode.
    for (int i = 0; i < 10; i++) mem[(100 + i) % 128] = tbl[6].bytes[79 - 8*i -: 8];
    addr = 7'd100; is_signed = 1'b0; is_64 = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("async reset value", value, 64'd0);
    chk("async reset len/err", {58'd0, length, error}, 64'd0);
    chk("async reset mem port", {53'd0, mem_addr, mem_extra}, 64'd0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no activity after reset", 64'(ndone), 64'd0);
    run_vec(tbl[1], "post-reset");

    // Randomised operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] a;
      logic sgn, w64, merr;
      int len;
      a = 7'($urandom); sgn = 1'($urandom); w64 = 1'($urandom);
      merr = ($urandom_range(0, 15) == 0);
      len = $urandom_range(1, 11);
      for (int i = 0; i < 10; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b[6:0] = (b[0] ? 7'h7F : 7'h00);
        b[7] = (i < len - 1);
        mem[(int'(a) + i) % 128] = b;
      end
      ref_decode(a, sgn, w64, merr, ev, el, ee);
      mem_error = merr;
      do_op(a, sgn, w64, -1, lat, v, l, e, bok, ca, cx, pok);
      mem_error = 1'b0;
      chk($sformatf("rand%0d value", n), v, ev);
      chk($sformatf("rand%0d length", n), 64'(l), 64'(el));
      chk($sformatf("rand%0d error", n), 64'(e), 64'(ee));
      chk($sformatf("rand%0d latency", n), 64'(lat), merr ? 64'd2 : 64'(int'(el) + 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
